// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if -- bus bundle around the instruction-fetch stage.
//   Instruction-memory side : imem_req_o, imem_addr_o (fetch -> memory)
//                             imem_ack_i, imem_data_i (memory -> fetch)
//   Decode side             : id_valid_o, id_instr_o, id_pc4_o (fetch -> decode)
//                             id_ready_i (decode -> fetch)
// Signal suffixes are given from the fetch unit's point of view.
// master = fetch unit, slave = memory/decode environment.
// ---------------------------------------------------------------------------
interface fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc4_o;

  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc4_o,
    input  imem_ack_i, imem_data_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc4_o,
    output imem_ack_i, imem_data_i, id_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction-fetch stage between the PC register and decode.
// Issues one outstanding instruction-memory request at a time for the
// current PC, buffers returned instructions together with PC+4 in a small
// FIFO toward decode, and pulses pcWrite_o to advance/redirect the PC.
// A branch flush discards the queue and drops any in-flight fetch.
//
// Ports
//   clk_i      : clock, rising edge
//   start_i    : asynchronous active-low reset (low = reset, high = run)
//   pc_i       : current PC from the PC register
//   pcWrite_o  : PC register write enable (combinational)
//   flush_i    : branch redirect, discards in-flight and queued fetches
//   bus        : fetch_if.master (imem request/ack + decode valid/ready)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int DEPTH = 2   // queue entries, power of 2, >= 2
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  output logic        pcWrite_o,
  input  logic        flush_i,
  fetch_if.master     bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e      state_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] pc4_q;

  // Each entry holds {pc4, instr}.
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push;
  logic pop;

  // Only an ack that completes a live request (REQ) delivers data; acks
  // in DROP belong to a flushed fetch and acks in IDLE are protocol errors.
  assign push = (state_q == REQ) && bus.imem_ack_i && !flush_i;
  assign pop  = (count_q != '0) && bus.id_ready_i && !flush_i;

  assign pcWrite_o = start_i && (flush_i || ((state_q == REQ) && bus.imem_ack_i));

  // ---------------- fetch FSM (registered outputs) -------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      pc4_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if ((count_q < CW'(DEPTH)) && !flush_i) begin
            addr_q  <= pc_i;
            pc4_q   <= pc_i + 32'd4;   // wraps mod 2^32
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.imem_ack_i) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end else if (flush_i) begin
            // Request must stay asserted until the memory acks it.
            state_q <= DROP;
          end
        end
        DROP: begin
          if (bus.imem_ack_i) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------- queue pointer / count next-state -----------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Realign both pointers so the emptied queue restarts consistently.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: the storage array is reset deliberately; the head is read
  // combinationally and must show zeros after reset until the first push.
  // It is only DEPTH entries, so the reset fan-out stays small.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= {pc4_q, bus.imem_data_i};
    end
  end

  // ---------------- outputs -------------------------------------------------
  assign bus.imem_req_o  = req_q;
  assign bus.imem_addr_o = addr_q;
  assign bus.id_valid_o  = (count_q != '0);
  assign bus.id_instr_o  = mem_q[rd_ptr_q][31:0];
  assign bus.id_pc4_o    = mem_q[rd_ptr_q][63:32];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- directed, table-driven bench for fetch_unit (DEPTH=2).
// Each vector is one clock cycle: inputs are driven 1 ns after the rising
// edge, outputs are compared on the falling edge. The bench plays the PC
// register by moving pc_i to the next value after each pcWrite_o pulse.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        start_i;
  logic [31:0] pc_i;
  logic        pcWrite_o;
  logic        flush_i;

  fetch_if bus ();

  fetch_unit #(.DEPTH(2)) dut (
    .clk_i     (clk_i),
    .start_i   (start_i),
    .pc_i      (pc_i),
    .pcWrite_o (pcWrite_o),
    .flush_i   (flush_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        ack;
    logic [31:0] data;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;   // compared only when e_req=1
    logic        e_pcw;
    logic        e_valid;
    logic [31:0] e_instr;  // compared only when e_valid=1
    logic [31:0] e_pc4;    // compared only when e_valid=1
  } vec_t;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  function automatic vec_t mk(input logic [31:0] pc, input logic flush,
                              input logic ack, input logic [31:0] data,
                              input logic ready, input logic e_req,
                              input logic [31:0] e_addr, input logic e_pcw,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4);
    vec_t v;
    v.pc = pc; v.flush = flush; v.ack = ack; v.data = data; v.ready = ready;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pcw = e_pcw;
    v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Apply one cycle's inputs (called 1 ns after a rising edge), compare on
  // the falling edge, and return 1 ns after the next rising edge.
  task automatic step(input string name, input vec_t v);
    logic bad;
    pc_i            = v.pc;
    flush_i         = v.flush;
    bus.imem_ack_i  = v.ack;
    bus.imem_data_i = v.data;
    bus.id_ready_i  = v.ready;
    @(negedge clk_i);
    bad = (bus.imem_req_o !== v.e_req) || (pcWrite_o !== v.e_pcw) ||
          (bus.id_valid_o !== v.e_valid);
    if (v.e_req && (bus.imem_addr_o !== v.e_addr)) bad = 1'b1;
    if (v.e_valid && ((bus.id_instr_o !== v.e_instr) ||
                      (bus.id_pc4_o !== v.e_pc4))) bad = 1'b1;
    vec_cnt++;
    if (bad) begin
      miss_cnt++;
      $display("FAIL %s: got req=%b addr=%h pcw=%b valid=%b instr=%h pc4=%h; expected req=%b addr=%h pcw=%b valid=%b instr=%h pc4=%h",
               name, bus.imem_req_o, bus.imem_addr_o, pcWrite_o, bus.id_valid_o,
               bus.id_instr_o, bus.id_pc4_o, v.e_req, v.e_addr, v.e_pcw,
               v.e_valid, v.e_instr, v.e_pc4);
    end
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl [15];

  initial begin
    // Single fetch (ack 3 cycles after req) followed by backpressure.
    //            pc          fl ack data          rdy req addr          pcw vld instr         pc4
    tbl[0]  = mk(32'h100, 0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         32'h0);
    tbl[1]  = mk(32'h100, 0, 0, 32'h0,         1, 1, 32'h100,       0, 0, 32'h0,         32'h0);
    tbl[2]  = mk(32'h100, 0, 0, 32'h0,         1, 1, 32'h100,       0, 0, 32'h0,         32'h0);
    tbl[3]  = mk(32'h100, 0, 1, 32'hDEADBEEF,  1, 1, 32'h100,       1, 0, 32'h0,         32'h0);
    tbl[4]  = mk(32'h104, 0, 0, 32'h0,         1, 0, 32'h0,         0, 1, 32'hDEADBEEF,  32'h104);
    tbl[5]  = mk(32'h104, 0, 1, 32'h11111111,  0, 1, 32'h104,       1, 0, 32'h0,         32'h0);
    tbl[6]  = mk(32'h108, 0, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h11111111,  32'h108);
    tbl[7]  = mk(32'h108, 0, 1, 32'h22222222,  0, 1, 32'h108,       1, 1, 32'h11111111,  32'h108);
    tbl[8]  = mk(32'h10C, 0, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h11111111,  32'h108);
    tbl[9]  = mk(32'h10C, 0, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h11111111,  32'h108);
    tbl[10] = mk(32'h10C, 0, 0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h11111111,  32'h108);
    tbl[11] = mk(32'h10C, 0, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h22222222,  32'h10C);
    tbl[12] = mk(32'h10C, 0, 0, 32'h0,         0, 1, 32'h10C,       0, 1, 32'h22222222,  32'h10C);
    tbl[13] = mk(32'h10C, 0, 1, 32'h33333333,  1, 1, 32'h10C,       1, 1, 32'h22222222,  32'h10C);
    tbl[14] = mk(32'h110, 0, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h33333333,  32'h110);

    // ---------------- reset state ----------------
    start_i         = 1'b0;
    pc_i            = 32'h0;
    flush_i         = 1'b0;
    bus.imem_ack_i  = 1'b0;
    bus.imem_data_i = 32'h0;
    bus.id_ready_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_req",   {31'h0, bus.imem_req_o}, 32'h0);
    check("rst_addr",  bus.imem_addr_o, 32'h0);
    check("rst_valid", {31'h0, bus.id_valid_o}, 32'h0);
    check("rst_instr", bus.id_instr_o, 32'h0);
    check("rst_pc4",   bus.id_pc4_o, 32'h0);
    check("rst_pcw",   {31'h0, pcWrite_o}, 32'h0);
    start_i = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < 15; i++) step($sformatf("tbl%0d", i), tbl[i]);
    // The last table edge issued a request for 0x110: DUT is now in REQ.

    // ---------------- reset mid-request ----------------
    flush_i = 1'b1;        // pcWrite_o must still be gated by reset
    start_i = 1'b0;
    #1;
    check("midrst_req",   {31'h0, bus.imem_req_o}, 32'h0);
    check("midrst_valid", {31'h0, bus.id_valid_o}, 32'h0);
    check("midrst_pcw",   {31'h0, pcWrite_o}, 32'h0);
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    step("rel_idle", mk(32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    step("rel_req0", mk(32'h0, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0));

    // ---------------- flush while in flight, queue non-empty ----------------
    step("fl_push",  mk(32'h0,   0, 1, 32'hAAAA0000, 0, 1, 32'h0, 1, 0, 32'h0,         32'h0));
    step("fl_idle",  mk(32'h4,   0, 0, 32'h0,        0, 0, 32'h0, 0, 1, 32'hAAAA0000,  32'h4));
    step("fl_req4",  mk(32'h4,   0, 0, 32'h0,        0, 1, 32'h4, 0, 1, 32'hAAAA0000,  32'h4));
    step("fl_flush", mk(32'h4,   1, 0, 32'h0,        0, 1, 32'h4, 1, 1, 32'hAAAA0000,  32'h4));
    step("fl_drop",  mk(32'h200, 0, 0, 32'h0,        1, 1, 32'h4, 0, 0, 32'h0,         32'h0));
    step("fl_ack",   mk(32'h200, 0, 1, 32'hBAD0BAD0, 1, 1, 32'h4, 0, 0, 32'h0,         32'h0));
    step("fl_idle2", mk(32'h200, 0, 0, 32'h0,        1, 0, 32'h0, 0, 0, 32'h0,         32'h0));
    step("fl_req200",mk(32'h200, 0, 0, 32'h0,        1, 1, 32'h200, 0, 0, 32'h0,       32'h0));

    // ---------------- flush coincident with ack ----------------
    step("fa_both",  mk(32'h200, 1, 1, 32'h55555555, 1, 1, 32'h200, 1, 0, 32'h0,       32'h0));
    step("fa_idle",  mk(32'h300, 0, 0, 32'h0,        1, 0, 32'h0,   0, 0, 32'h0,       32'h0));
    step("fa_req300",mk(32'h300, 0, 0, 32'h0,        1, 1, 32'h300, 0, 0, 32'h0,       32'h0));

    // ---------------- PC+4 wrap and simultaneous push/pop ----------------
    step("wr_push",  mk(32'h300,      0, 1, 32'h66666666, 0, 1, 32'h300,      1, 0, 32'h0,        32'h0));
    step("wr_idle",  mk(32'hFFFFFFFC, 0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h66666666, 32'h304));
    step("wr_req",   mk(32'hFFFFFFFC, 0, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 0, 1, 32'h66666666, 32'h304));
    step("wr_pushpop",mk(32'hFFFFFFFC,0, 1, 32'h77777777, 1, 1, 32'hFFFFFFFC, 1, 1, 32'h66666666, 32'h304));
    step("wr_head",  mk(32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h77777777, 32'h0));
    // One entry left after push+pop: the next request must still issue.
    step("wr_req0",  mk(32'h0,        0, 0, 32'h0,        0, 1, 32'h0,        0, 1, 32'h77777777, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
